// File: rtl/tinker_rf_pkg.sv
// Shared register-file constants and address type for the Tinker core (decode stage and regfile).
package tinker_rf_pkg;

    localparam int unsigned RF_DATA_W   = 64;
    localparam int unsigned REG_AW      = 5;
    localparam int unsigned RF_NUM_REGS = 32'(1) << REG_AW;
    localparam int unsigned RF_SP_IDX   = 31;
    localparam logic [63:0] RF_SP_RESET = 64'h80000;
    localparam int unsigned RF_CNT_W    = 2;

    typedef logic [REG_AW-1:0] reg_addr_t;

endpackage

// File: rtl/tinker_sb_counter.sv
// Per-register pending-write counter: issue increments, writeback decrements, flush keeps only
// a same-cycle issue. Underflow is flagged combinationally for the owner to latch.
module tinker_sb_counter #(
    parameter int unsigned CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    input  logic             flush,
    output logic [CNT_W-1:0] cnt,
    output logic             at_max_c,
    output logic             underflow_c
);

    logic [CNT_W-1:0] cnt_nxt;

    always_comb begin
        cnt_nxt     = cnt;
        underflow_c = 1'b0;
        if (flush) begin
            cnt_nxt = inc ? CNT_W'(1) : '0;
        end else if (inc && !dec) begin
            cnt_nxt = cnt + CNT_W'(1);
        end else if (dec && !inc) begin
            if (cnt != '0) cnt_nxt = cnt - CNT_W'(1);
            else           underflow_c = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt <= '0;
        else       cnt <= cnt_nxt;
    end

    assign at_max_c = (cnt == {CNT_W{1'b1}});

endmodule

// File: rtl/tinker_regfile_sb.sv
// Tinker register file with write-through read ports and a per-register scoreboard.
// Build option TINKER_RF_ZERO_REG_EN hardwires register 0 to zero.
module tinker_regfile_sb
    import tinker_rf_pkg::*;
#(
    parameter int unsigned DATA_W   = RF_DATA_W,
    parameter int unsigned NUM_REGS = RF_NUM_REGS,
    parameter int unsigned NUM_RD   = 3,
    parameter int unsigned SP_IDX   = RF_SP_IDX,
    parameter logic [63:0] SP_RESET = RF_SP_RESET,
    parameter int unsigned CNT_W    = RF_CNT_W,
    localparam int unsigned AW      = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     issue_valid,
    input  logic [AW-1:0]            issue_dst,
    output logic                     issue_ready,
    input  logic                     wb_valid,
    input  logic [AW-1:0]            wb_addr,
    input  logic [DATA_W-1:0]        wb_data,
    input  logic                     flush,
    output logic [DATA_W-1:0]        sp_val,
    output logic                     sb_err
);

`ifdef TINKER_RF_ZERO_REG_EN
    localparam bit ZERO_EN = 1'b1;
`else
    localparam bit ZERO_EN = 1'b0;
`endif

    logic [DATA_W-1:0]   regs  [NUM_REGS];
    logic [CNT_W-1:0]    cnt   [NUM_REGS];
    logic [NUM_REGS-1:0] at_max;
    logic [NUM_REGS-1:0] underflow;
    logic                issue_fire;
    logic [AW-1:0]       raddr [NUM_RD+1];
    logic [DATA_W-1:0]   rdat  [NUM_RD+1];

    // A same-cycle writeback frees a slot, so a full counter can still accept
    assign issue_ready = !at_max[issue_dst] || (wb_valid && (wb_addr == issue_dst));
    assign issue_fire  = issue_valid && issue_ready;

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_sb
        localparam bit IS_ZERO = ZERO_EN && (r == 0);
        logic inc;
        logic dec;
        assign inc = !IS_ZERO && issue_fire && (issue_dst == AW'(r));
        assign dec = !IS_ZERO && wb_valid   && (wb_addr   == AW'(r));

        tinker_sb_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk        (clk),
            .reset      (reset),
            .inc        (inc),
            .dec        (dec),
            .flush      (flush),
            .cnt        (cnt[r]),
            .at_max_c   (at_max[r]),
            .underflow_c(underflow[r])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned r = 0; r < NUM_REGS; r++)
                regs[r] <= (r == SP_IDX) ? DATA_W'(SP_RESET) : '0;
        end else if (wb_valid && !(ZERO_EN && (wb_addr == '0))) begin
            regs[wb_addr] <= wb_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)           sb_err <= 1'b0;
        else if (|underflow) sb_err <= 1'b1;
    end

    // The stack pointer is served as an extra internal read port
    always_comb begin
        raddr = '{default: '0};
        for (int i = 0; i < NUM_RD; i++) raddr[i] = rd_addr[i*AW +: AW];
        raddr[NUM_RD] = AW'(SP_IDX);
    end

    always_comb begin
        rdat = '{default: '0};
        for (int i = 0; i <= NUM_RD; i++) begin
            if (ZERO_EN && (raddr[i] == '0))            rdat[i] = '0;
            else if (wb_valid && (wb_addr == raddr[i])) rdat[i] = wb_data;
            else                                        rdat[i] = regs[raddr[i]];
        end
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            rd_data[i*DATA_W +: DATA_W] = rdat[i];
            rd_busy[i] = (cnt[raddr[i]] != '0) &&
                         !((cnt[raddr[i]] == CNT_W'(1)) && wb_valid && (wb_addr == raddr[i]));
        end
    end

    assign sp_val = rdat[NUM_RD];

endmodule

// File: doc/tinker_regfile_sb.md
Name: tinker_regfile_sb

Overview:
Parametrised register file for the pipelined Tinker core, with an integrated per-register scoreboard for hazard detection. Provides NUM_RD combinational read ports with same-cycle write-through bypass and one writeback port. Per-register pending-write counters let the ID stage stall on RAW/WAW hazards. A flush input squashes all in-flight writes on branch redirect. Sits between ID (read/issue) and WB (write/retire).

Parameters:
DATA_W, 64, register width in bits
NUM_REGS, 32, number of architectural registers (power of 2, >=2)
NUM_RD, 3, number of read ports (rs, rt, rd)
SP_IDX, 31, index of the stack-pointer register
SP_RESET, 64'h80000, reset value of register SP_IDX (truncated to DATA_W)
CNT_W, 2, width of each pending-write counter; max in flight per register = 2^CNT_W-1

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous, active-high
rd_addr  in  NUM_RD*AW  packed read addresses, AW=$clog2(NUM_REGS), port i at [i*AW +: AW]
rd_data  out  NUM_RD*DATA_W  packed read data, combinational
rd_busy  out  NUM_RD  port i register has pending write (counter != 0, after same-cycle wb)
issue_valid  in  1  ID issues an instruction writing issue_dst
issue_dst  in  AW  destination register of issuing instruction
issue_ready  out  1  issue_dst counter below max; issue accepted only when issue_valid && issue_ready
wb_valid  in  1  WB writes register
wb_addr  in  AW  writeback address
wb_data  in  DATA_W  writeback data
flush  in  1  clear all pending counters (pipeline squash)
sp_val  out  DATA_W  current value of register SP_IDX (bypassed like a read port)
sb_err  out  1  sticky: wb_valid to a register whose counter was 0 (outside flush cycle)

Behaviour:
- Reset (async, immediate): all registers 0 except SP_IDX = SP_RESET; all counters 0; sb_err 0. Outputs therefore: rd_data = 0 (or SP_RESET on SP_IDX), rd_busy 0, issue_ready 1, sp_val SP_RESET.
- Reads: zero latency. If wb_valid && wb_addr==rd_addr[i], rd_data[i]=wb_data, else stored value. Same for sp_val.
- Write: on posedge clk when wb_valid, reg[wb_addr] <= wb_data. Data written regardless of flush or counter state.
- Counter update per register r, evaluated each posedge:
  - inc = issue_valid && issue_ready && issue_dst==r; dec = wb_valid && wb_addr==r.
  - flush=1: cnt <= inc ? 1 : 0 (issue in flush cycle is younger, survives; dec ignored).
  - else inc&&dec: unchanged; inc only: +1; dec only: -1 if nonzero, else stays 0 and sb_err <= 1.
- issue_ready = (cnt[issue_dst] != max) || (wb_valid && wb_addr==issue_dst); never saturates or wraps.
- rd_busy[i] = cnt[rd_addr[i]] != 0 and not (cnt==1 && same-cycle wb to that register). Bypassed data is then valid.
- sb_err clears only on reset.
- Reset mid-operation: all state discarded immediately; no pending write survives.

Optional Feature:
TINKER_RF_ZERO_REG_EN. Defined: register 0 hardwired to zero. Writes to 0 are discarded, reads return 0 (no bypass), its counter stays 0, rd_busy never set, issue_ready always 1 for dst 0, and wb to 0 never sets sb_err. Undefined: register 0 is an ordinary register.

Decomposition:
- Package tinker_rf_pkg: DATA_W default, REG_AW, SP_IDX, SP_RESET, CNT_W defaults, and typedef reg_addr_t. Shared with the core's decode stage.
- One sub-module, tinker_sb_counter: a single CNT_W counter with inc/dec/flush, an at_max output, and an underflow pulse. Generate NUM_REGS instances.

Test Plan:
- Reset, no stimulus -> rd_data for addr 5 = 0, addr 31 = 0x80000, sp_val 0x80000, issue_ready 1, rd_busy 0, sb_err 0.
- Issue dst 3, later wb 3 with 0xDEAD while reading 3 -> rd_busy 1 until wb cycle; in wb cycle rd_data=0xDEAD and rd_busy 0; next cycle stored 0xDEAD.
- Issue dst 7 three times (CNT_W=2) -> issue_ready 0 on 4th attempt. Same cycle as wb 7 -> issue_ready 1 and counter stays 3.
- Counters for 2 and 4 nonzero, flush with issue dst 4 -> cnt[2]=0, cnt[4]=1. Wb 2 on next cycle -> sb_err 1 and sticky.
- Wb to 9 with counter 0, no flush -> data written, sb_err 1. Assert reset mid-cycle -> sb_err 0 and reg 9 = 0 immediately.
- With TINKER_RF_ZERO_REG_EN: wb 0 with 0xFF -> read 0 returns 0 in the same and next cycle, sb_err stays 0.
